// File: rtl/up_down_counter_mod.sv
// Cascadable up/down counter with programmable modulus, wrap/saturate mode and a registered wrap pulse.
// q and wrap_pls update one cycle after the inputs; max_min/rco_b are combinational; en_b holds the count.
module up_down_counter_mod #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_b,
   input  logic         en_b,
   input  logic         load_b,
   input  logic         up,
   input  logic         sat,
   input  logic [N-1:0] mod_max,
   input  logic [N-1:0] load_in,
   output logic [N-1:0] q,
   output logic         max_min,
   output logic         rco_b,
   output logic         wrap_pls
);

   localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};
   localparam logic [N-1:0] ZERO = '0;

   logic [N-1:0] cnt_q, cnt_d;
   logic         wrap_q, wrap_d;
   logic         at_top, at_bottom;

   assign at_top    = (cnt_q >= mod_max);
   assign at_bottom = (cnt_q == ZERO);

   always_comb begin
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      if (!load_b) begin
         cnt_d = load_in;
      end else if (!en_b) begin
         if (up) begin
            if (!at_top) begin
               cnt_d = cnt_q + ONE;
            end else if (sat) begin
               cnt_d = mod_max;
            end else begin
               cnt_d  = ZERO;
               wrap_d = 1'b1;
            end
         end else begin
            // A count left above a lowered modulus is pulled back in range without a wrap.
            if (cnt_q > mod_max) begin
               cnt_d = mod_max;
            end else if (!at_bottom) begin
               cnt_d = cnt_q - ONE;
            end else if (!sat) begin
               cnt_d  = mod_max;
               wrap_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         cnt_q  <= ZERO;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         wrap_q <= wrap_d;
      end
   end

   assign q        = cnt_q;
   assign wrap_pls = wrap_q;
   assign max_min  = (up & at_top) | (~up & at_bottom);
   assign rco_b    = ~(max_min & ~en_b);

endmodule

// File: tb/tb_up_down_counter_mod.sv
// Bench for up_down_counter_mod: two stages cascaded through rco_b, checked against an integer model.
module tb_up_down_counter_mod;

   logic       clk = 1'b0;
   logic       rst_b, en_b, load_b, up, sat;
   logic [3:0] mod_max, load_in;
   logic [3:0] q0, q1;
   logic       mm0, mm1, rco0, rco1, wp0, wp1;

   int checks = 0;
   int failures = 0;

   int m_q0, m_q1;
   bit m_w0, m_w1;

   always #5 clk = ~clk;

   up_down_counter_mod #(.N(4)) dut0 (
      .clk(clk), .rst_b(rst_b), .en_b(en_b), .load_b(load_b), .up(up), .sat(sat),
      .mod_max(mod_max), .load_in(load_in), .q(q0), .max_min(mm0), .rco_b(rco0), .wrap_pls(wp0)
   );

   up_down_counter_mod #(.N(4)) dut1 (
      .clk(clk), .rst_b(rst_b), .en_b(rco0), .load_b(load_b), .up(up), .sat(sat),
      .mod_max(mod_max), .load_in(load_in), .q(q1), .max_min(mm1), .rco_b(rco1), .wrap_pls(wp1)
   );

   function automatic bit model_tc(input int qv, input bit u, input int mm);
      return u ? (qv >= mm) : (qv == 0);
   endfunction

   function automatic void model_next(input int qv, input bit ld, input bit enb, input bit u,
                                      input bit s, input int mm, input int li,
                                      output int qn, output bit wn);
      qn = qv;
      wn = 1'b0;
      if (!ld) qn = li;
      else if (!enb) begin
         if (u) begin
            if (qv < mm) qn = qv + 1;
            else if (s) qn = mm;
            else begin qn = 0; wn = 1'b1; end
         end else begin
            if (qv > mm) qn = mm;
            else if (qv > 0) qn = qv - 1;
            else if (!s) begin qn = mm; wn = 1'b1; end
         end
      end
   endfunction

   // Advance models and DUT by one rising edge; inputs are sampled as currently driven.
   task automatic tick();
      bit c;
      int n0, n1;
      bit w0, w1;
      c = model_tc(m_q0, up, int'(mod_max)) && !en_b;
      model_next(m_q0, load_b, en_b, up, sat, int'(mod_max), int'(load_in), n0, w0);
      model_next(m_q1, load_b, !c, up, sat, int'(mod_max), int'(load_in), n1, w1);
      @(posedge clk);
      #1;
      m_q0 = n0; m_w0 = w0;
      m_q1 = n1; m_w1 = w1;
   endtask

   task automatic load_both(input int v);
      load_b = 1'b0; load_in = v[3:0];
      tick();
      load_b = 1'b1;
   endtask

   task automatic test_reset();
      rst_b = 1'b0; en_b = 1'b1; load_b = 1'b1; up = 1'b1; sat = 1'b0;
      mod_max = 4'd9; load_in = 4'd0;
      m_q0 = 0; m_q1 = 0; m_w0 = 0; m_w1 = 0;
      #2;
      checks++;
      if (q0 !== 4'd0 || q1 !== 4'd0) begin
         failures++; $display("FAIL reset_q: q0=%0d q1=%0d expected 0 0", q0, q1);
      end
      checks++;
      if (wp0 !== 1'b0 || wp1 !== 1'b0) begin
         failures++; $display("FAIL reset_wrap: wp0=%b wp1=%b expected 0 0", wp0, wp1);
      end
      @(posedge clk); #1;
      checks++;
      if (q0 !== 4'd0) begin
         failures++; $display("FAIL reset_hold: q0=%0d expected 0", q0);
      end
      rst_b = 1'b1;
   endtask

   task automatic test_up_wrap();
      int pulses = 0;
      mod_max = 4'd9; sat = 1'b0; up = 1'b1;
      load_both(0);
      en_b = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         checks++;
         if (q0 !== 4'((i + 1) % 10) || q0 !== m_q0[3:0]) begin
            failures++; $display("FAIL up_wrap_q[%0d]: got %0d expected %0d", i, q0, (i + 1) % 10);
         end
         checks++;
         if (wp0 !== m_w0) begin
            failures++; $display("FAIL up_wrap_pls[%0d]: got %b expected %b", i, wp0, m_w0);
         end
         checks++;
         if (mm0 !== (q0 == 4'd9) || rco0 !== !(q0 == 4'd9)) begin
            failures++; $display("FAIL up_wrap_tc[%0d]: max_min=%b rco_b=%b q=%0d", i, mm0, rco0, q0);
         end
         if (wp0 === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 1) begin
         failures++; $display("FAIL up_wrap_pulse_count: got %0d expected 1", pulses);
      end
      en_b = 1'b1;
   endtask

   task automatic test_down_wrap();
      mod_max = 4'd9; sat = 1'b0; up = 1'b0;
      load_both(0);
      en_b = 1'b0;
      for (int i = 0; i < 11; i++) begin
         tick();
         checks++;
         if (q0 !== 4'(9 - (i % 10))) begin
            failures++; $display("FAIL down_wrap_q[%0d]: got %0d expected %0d", i, q0, 9 - (i % 10));
         end
         checks++;
         if (wp0 !== ((i == 0) || (i == 10)) || rco0 !== !(q0 == 4'd0)) begin
            failures++; $display("FAIL down_wrap_flags[%0d]: wrap_pls=%b rco_b=%b q=%0d", i, wp0, rco0, q0);
         end
      end
      en_b = 1'b1;
   endtask

   task automatic test_saturate();
      int exp_up [4] = '{4, 5, 5, 5};
      sat = 1'b1; mod_max = 4'd5; up = 1'b1;
      load_both(3);
      en_b = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (q0 !== 4'(exp_up[i]) || wp0 !== 1'b0) begin
            failures++; $display("FAIL sat_up[%0d]: q=%0d wrap=%b expected %0d 0", i, q0, wp0, exp_up[i]);
         end
      end
      en_b = 1'b1; up = 1'b0;
      load_both(1);
      en_b = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (q0 !== 4'd0 || wp0 !== 1'b0) begin
            failures++; $display("FAIL sat_down[%0d]: q=%0d wrap=%b expected 0 0", i, q0, wp0);
         end
      end
      en_b = 1'b1; sat = 1'b0;
   endtask

   task automatic test_load_priority();
      mod_max = 4'd9; sat = 1'b0; up = 1'b1; en_b = 1'b1;
      load_both(12);
      checks++;
      if (q0 !== 4'd12) begin
         failures++; $display("FAIL load_out_of_range: got %0d expected 12", q0);
      end
      en_b = 1'b0;
      tick();
      checks++;
      if (q0 !== 4'd0 || wp0 !== 1'b1) begin
         failures++; $display("FAIL load_then_wrap: q=%0d wrap=%b expected 0 1", q0, wp0);
      end
      #3 rst_b = 1'b0;
      #1;
      checks++;
      if (q0 !== 4'd0 || wp0 !== 1'b0) begin
         failures++; $display("FAIL async_reset_wrap: q=%0d wrap=%b expected 0 0", q0, wp0);
      end
      m_q0 = 0; m_q1 = 0; m_w0 = 0; m_w1 = 0;
      en_b = 1'b1;
      #1 rst_b = 1'b1;
      tick();
      load_both(7);
      #2 rst_b = 1'b0;
      #1;
      checks++;
      if (q0 !== 4'd0 || q1 !== 4'd0) begin
         failures++; $display("FAIL async_reset_midcount: q0=%0d q1=%0d expected 0 0", q0, q1);
      end
      m_q0 = 0; m_q1 = 0; m_w0 = 0; m_w1 = 0;
      #1 rst_b = 1'b1;
      tick();
      checks++;
      if (q0 !== 4'd0 || q1 !== 4'd0) begin
         failures++; $display("FAIL reset_release: q0=%0d q1=%0d expected 0 0", q0, q1);
      end
   endtask

   task automatic test_cascade();
      int pulses1 = 0;
      int bad_inc = 0;
      int model_err = 0;
      logic [3:0] pq0, pq1;
      mod_max = 4'd9; sat = 1'b0; up = 1'b1; en_b = 1'b1;
      load_both(0);
      en_b = 1'b0;
      for (int i = 0; i < 100; i++) begin
         pq0 = q0; pq1 = q1;
         tick();
         if (q1 !== pq1 && !(pq0 == 4'd9 && q0 == 4'd0)) bad_inc++;
         if (q0 !== m_q0[3:0] || q1 !== m_q1[3:0] || wp1 !== m_w1) model_err++;
         if (wp1 === 1'b1) pulses1++;
      end
      checks++;
      if (q1 !== 4'd0 || q0 !== 4'd0) begin
         failures++; $display("FAIL cascade_end: (q1,q0)=(%0d,%0d) expected (0,0)", q1, q0);
      end
      checks++;
      if (pulses1 != 1) begin
         failures++; $display("FAIL cascade_stage1_pulses: got %0d expected 1", pulses1);
      end
      checks++;
      if (bad_inc != 0 || model_err != 0) begin
         failures++; $display("FAIL cascade_steps: bad_inc=%0d model_err=%0d expected 0 0", bad_inc, model_err);
      end
      en_b = 1'b1;
   endtask

   task automatic test_edges();
      mod_max = 4'd0; sat = 1'b0; en_b = 1'b1;
      load_both(0);
      en_b = 1'b0;
      for (int i = 0; i < 4; i++) begin
         up = i[0];
         tick();
         checks++;
         if (q0 !== 4'd0 || wp0 !== 1'b1 || mm0 !== 1'b1) begin
            failures++; $display("FAIL modmax0[%0d]: q=%0d wrap=%b max_min=%b expected 0 1 1", i, q0, wp0, mm0);
         end
      end
      en_b = 1'b1; up = 1'b1; mod_max = 4'd15;
      load_both(14);
      en_b = 1'b0;
      tick();
      checks++;
      if (q0 !== 4'd15 || wp0 !== 1'b0) begin
         failures++; $display("FAIL modmax15_top: q=%0d wrap=%b expected 15 0", q0, wp0);
      end
      tick();
      checks++;
      if (q0 !== 4'd0 || wp0 !== 1'b1) begin
         failures++; $display("FAIL modmax15_wrap: q=%0d wrap=%b expected 0 1", q0, wp0);
      end
      en_b = 1'b1;
   endtask

   task automatic test_random();
      int errs = 0;
      for (int i = 0; i < 400; i++) begin
         en_b    = ($urandom_range(0, 3) == 0);
         load_b  = ($urandom_range(0, 15) != 0);
         up      = $urandom_range(0, 1);
         sat     = ($urandom_range(0, 3) == 0);
         load_in = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 19) == 0) mod_max = 4'($urandom_range(0, 15));
         #1;
         if (mm0 !== model_tc(m_q0, up, int'(mod_max)) ||
             rco0 !== !(model_tc(m_q0, up, int'(mod_max)) && !en_b)) errs++;
         tick();
         if (q0 !== m_q0[3:0] || wp0 !== m_w0 || q1 !== m_q1[3:0] || wp1 !== m_w1) begin
            errs++;
            if (errs < 5)
               $display("FAIL random[%0d]: q0=%0d/%0d wp0=%b/%b q1=%0d/%0d wp1=%b/%b (got/expected)",
                        i, q0, m_q0, wp0, m_w0, q1, m_q1, wp1, m_w1);
         end
      end
      checks++;
      if (errs != 0) begin
         failures++; $display("FAIL random_total: mismatching cycles=%0d expected 0", errs);
      end
      load_b = 1'b1; en_b = 1'b1;
   endtask

   initial begin
      test_reset();
      test_up_wrap();
      test_down_wrap();
      test_saturate();
      test_load_priority();
      test_cascade();
      test_edges();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
